// File: rtl/md_issuer.sv
// Issue controller between the pipeline and the multiply/divide unit:
// it starts mul/div operations, performs HI/LO moves and answers mfhi/mflo reads.
module md_issuer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        err_divz,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_rd1,
  output logic [31:0] md_rd2,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] MOVE  = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  // op 6 doubles as the unit's abort command
  localparam logic [2:0] OP_ABORT = 3'd6;

  logic [2:0] state;
  logic [2:0] last_op;
  logic [2:0] md_op_q;
  logic       rsp_valid_q;
  logic       accept;
  logic       div_by_zero;

  assign req_ready   = (state == IDLE) & ~md_busy & ~flush & ~reset;
  assign accept      = req_valid & req_ready;
  assign div_by_zero = ~req_op[2] & req_op[1] & (req_b == '0);

  // flush must act in the very cycle it is seen, so these two are qualified after the flop
  assign rsp_valid = rsp_valid_q & ~flush;
  assign md_op     = (state == MOVE && flush) ? last_op : md_op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_op     <= 3'd0;
      md_op_q     <= 3'd0;
      md_start    <= 1'b0;
      md_rd1      <= '0;
      md_rd2      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data    <= '0;
      err_divz    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; later assignments in the same block win,
      // which makes every pulse output one cycle wide without extra clearing logic.
      md_start    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_divz    <= 1'b0;
      md_op_q     <= last_op;

      case (state)
        IDLE: begin
          if (accept) begin
            md_rd1 <= req_a;
            md_rd2 <= req_b;
            if (!req_op[2]) begin
              if (div_by_zero) begin
                err_divz <= 1'b1;
              end else begin
                md_start <= 1'b1;
                md_op_q  <= req_op;
                last_op  <= req_op;
                state    <= ISSUE;
              end
            end else if (!req_op[1]) begin
              md_op_q <= req_op;
              state   <= MOVE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_data    <= req_op[0] ? md_lo : md_hi;
              state       <= READ;
            end
          end
        end

        ISSUE, WAIT: begin
          if (flush) begin
            md_op_q <= OP_ABORT;
            state   <= IDLE;
          end else if (state == ISSUE) begin
            state <= WAIT;
          end else if (!md_busy) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issuer.sv
// Directed bench for md_issuer with a small behavioural multiply/divide unit
// (fixed latency, abort on op 6, HI/LO writes on op 4/5).
module tb_md_issuer;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, rsp_valid, err_divz, md_start, md_busy;
  logic [31:0] rsp_data, md_rd1, md_rd2, md_hi, md_lo;
  logic [2:0]  md_op;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  md_issuer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_divz(err_divz),
    .md_start(md_start), .md_op(md_op), .md_rd1(md_rd1), .md_rd2(md_rd2),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo)
  );

  // behavioural multiply/divide unit
  logic [31:0] hi_r = '0, lo_r = '0, pend_hi = '0, pend_lo = '0;
  logic        busy_r = 1'b0;
  int          cnt = 0;
  assign md_busy = busy_r;
  assign md_hi   = hi_r;
  assign md_lo   = lo_r;

  function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    unit_calc = '0;
    case (op)
      3'd0: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); unit_calc = sp; end
      3'd1: unit_calc = {32'd0, a} * {32'd0, b};
      3'd2: if (b != 0) unit_calc = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      3'd3: if (b != 0) unit_calc = {a % b, a / b};
      default: unit_calc = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (md_op === 3'd6) begin
      busy_r <= 1'b0;
      cnt    <= 0;
    end else if (md_start === 1'b1) begin
      busy_r <= 1'b1;
      cnt    <= LAT;
      {pend_hi, pend_lo} <= unit_calc(md_op, md_rd1, md_rd2);
    end else if (busy_r) begin
      if (cnt == 1) begin
        busy_r <= 1'b0;
        hi_r   <= pend_hi;
        lo_r   <= pend_lo;
      end
      cnt <= cnt - 1;
    end else if (md_op === 3'd4) begin
      hi_r <= md_rd1;
    end else if (md_op === 3'd5) begin
      lo_r <= md_rd1;
    end
  end

  always @(posedge clk) if (md_start === 1'b1) start_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // presents a request, waits (bounded) for acceptance, returns one cycle after the accepting edge
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int waited);
    waited = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_timeout op=%0d: req_ready=%b want 1", op, req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  // reads HI (op 6) or LO (op 7) and compares the response
  task automatic read_hilo(input logic [2:0] op, input logic [31:0] exp, input string name);
    int w;
    do_req(op, 32'd0, 32'd0, w);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", name, rsp_valid); end
    n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, rsp_data, exp); end
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got %b want 0", name, rsp_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6; flush = 1'b1;
    step(); step();
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", md_start); end
    n_checks++; if (md_op !== 3'd0) begin n_fail++; $display("FAIL rst_op: got %0d want 0", md_op); end
    n_checks++; if (md_rd1 !== 32'd0 || md_rd2 !== 32'd0) begin n_fail++; $display("FAIL rst_rd: got %h/%h want 0/0", md_rd1, md_rd2); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_rsp: got %b/%h want 0/0", rsp_valid, rsp_data); end
    n_checks++; if (err_divz !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_divz); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_mult();
    int w, s0, cyc;
    logic bad;
    s0 = start_cnt; bad = 1'b0; cyc = 0;
    do_req(3'd0, 32'hFFFF_FFFD, 32'd5, w);
    n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL mult_start: got %b want 1", md_start); end
    n_checks++; if (md_op !== 3'd0) begin n_fail++; $display("FAIL mult_op: got %0d want 0", md_op); end
    n_checks++; if (md_rd1 !== 32'hFFFF_FFFD || md_rd2 !== 32'd5) begin n_fail++; $display("FAIL mult_rd: got %h/%h want fffffffd/5", md_rd1, md_rd2); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mult_ready_issue: got %b want 0", req_ready); end
    while (cyc < 50) begin
      step(); cyc++;
      if (md_busy !== 1'b1) break;
      if (req_ready !== 1'b0 || md_start !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL mult_ready_busy: ready/start seen high while busy"); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mult_ready_drop: got %b want 0", req_ready); end
    step();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mult_ready_back: got %b want 1", req_ready); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL mult_start_count: got %0d want 1", start_cnt - s0); end
    read_hilo(3'd7, 32'hFFFF_FFF1, "mult_lo");
    read_hilo(3'd6, 32'hFFFF_FFFF, "mult_hi");
  endtask

  task automatic test_stall();
    int w;
    do_req(3'd3, 32'd7, 32'd2, w);
    n_checks++; if (md_op !== 3'd3 || md_start !== 1'b1) begin n_fail++; $display("FAIL divu_issue: got op %0d start %b want 3/1", md_op, md_start); end
    do_req(3'd6, 32'd0, 32'd0, w);
    n_checks++; if (w !== 6) begin n_fail++; $display("FAIL stall_cycles: got %0d want 6", w); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %b/%h want 1/1", rsp_valid, rsp_data); end
    n_checks++; if (md_op !== 3'd3) begin n_fail++; $display("FAIL divu_idle_op: got %0d want 3", md_op); end
    step();
    read_hilo(3'd7, 32'd3, "divu_lo");
  endtask

  task automatic test_move();
    int w;
    do_req(3'd4, 32'h0000_1234, 32'd0, w);
    n_checks++; if (md_op !== 3'd4) begin n_fail++; $display("FAIL mthi_op: got %0d want 4", md_op); end
    n_checks++; if (md_rd1 !== 32'h1234 || md_start !== 1'b0) begin n_fail++; $display("FAIL mthi_rd1: got %h start %b want 1234/0", md_rd1, md_start); end
    step();
    n_checks++; if (md_op !== 3'd3) begin n_fail++; $display("FAIL mthi_revert: got %0d want 3", md_op); end
    do_req(3'd6, 32'd0, 32'd0, w);
    n_checks++; if (w !== 0) begin n_fail++; $display("FAIL move_b2b: got %0d wait cycles want 0", w); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234) begin n_fail++; $display("FAIL mthi_read: got %b/%h want 1/1234", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_divz();
    int w, s0;
    s0 = start_cnt;
    do_req(3'd2, 32'd9, 32'd0, w);
    n_checks++; if (err_divz !== 1'b1) begin n_fail++; $display("FAIL divz_pulse: got %b want 1", err_divz); end
    n_checks++; if (md_start !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL divz_idle: got start %b ready %b want 0/1", md_start, req_ready); end
    n_checks++; if (md_op !== 3'd3) begin n_fail++; $display("FAIL divz_op: got %0d want 3", md_op); end
    step();
    n_checks++; if (err_divz !== 1'b0) begin n_fail++; $display("FAIL divz_once: got %b want 0", err_divz); end
    n_checks++; if (start_cnt - s0 !== 0) begin n_fail++; $display("FAIL divz_nostart: got %0d starts want 0", start_cnt - s0); end
    read_hilo(3'd6, 32'h1234, "divz_hi");
    read_hilo(3'd7, 32'd3, "divz_lo");
  endtask

  task automatic test_flush();
    int w;
    do_req(3'd2, 32'd100, 32'd7, w);
    step();
    flush = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (md_op !== 3'd6 || md_start !== 1'b0) begin n_fail++; $display("FAIL flush_abort: got op %0d start %b want 6/0", md_op, md_start); end
    step();
    n_checks++; if (md_op !== 3'd2) begin n_fail++; $display("FAIL flush_revert: got %0d want 2", md_op); end
    n_checks++; if (md_busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_release: got busy %b ready %b want 0/1", md_busy, req_ready); end
    read_hilo(3'd6, 32'h1234, "flush_hi");
    read_hilo(3'd7, 32'd3, "flush_lo");
    do_req(3'd0, 32'd6, 32'd7, w);
    read_hilo(3'd7, 32'd42, "post_flush_lo");
    read_hilo(3'd6, 32'd0, "post_flush_hi");
    // flush during READ
    do_req(3'd6, 32'd0, 32'd0, w);
    flush = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_read: got %b want 0", rsp_valid); end
    step();
    flush = 1'b0;
    // flush during MOVE
    do_req(3'd5, 32'h0000_BEEF, 32'd0, w);
    flush = 1'b1;
    #1;
    n_checks++; if (md_op !== 3'd0) begin n_fail++; $display("FAIL flush_move_op: got %0d want 0", md_op); end
    step();
    flush = 1'b0;
    #1;
    read_hilo(3'd7, 32'd42, "flush_move_lo");
    // flush with a request in the same cycle
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd6;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_req_ready: got %b want 0", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_req_drop: got rsp %b ready %b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_wait();
    int w, cyc;
    do_req(3'd1, 32'd2, 32'd3, w);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (md_start !== 1'b0 || md_op !== 3'd0) begin n_fail++; $display("FAIL rw_op: got start %b op %0d want 0/0", md_start, md_op); end
    n_checks++; if (md_rd1 !== 32'd0 || md_rd2 !== 32'd0) begin n_fail++; $display("FAIL rw_rd: got %h/%h want 0/0", md_rd1, md_rd2); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || err_divz !== 1'b0) begin n_fail++; $display("FAIL rw_rsp: got %b/%h/%b want 0/0/0", rsp_valid, rsp_data, err_divz); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rw_ready_busy: got %b want 0", req_ready); end
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin step(); cyc++; end
    n_checks++; if (req_ready !== 1'b1 || md_busy !== 1'b0) begin n_fail++; $display("FAIL rw_ready_back: got ready %b busy %b want 1/0", req_ready, md_busy); end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0;
    req_op = 3'd0; req_a = '0; req_b = '0;
    step();
    test_reset();
    test_mult();
    test_stall();
    test_move();
    test_divz();
    test_flush();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
